pc_ras16: RTL



---
 rtl/pc_ras16_if.sv | 45 ++++
 rtl/pc_ras16.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_ras16_if.sv
// Bus interface for pc_ras16: command inputs, jump target and PC/RAS status.
// With PC_RAS_COUNT_EN defined, the interface also carries ras_count and takes a DEPTH parameter.
interface pc_ras16_if #(
  parameter int unsigned WIDTH = 16
`ifdef PC_RAS_COUNT_EN
  ,
  parameter int unsigned DEPTH = 8
`endif
);

  logic             en;
  logic             load;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] pc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

`ifdef PC_RAS_COUNT_EN
  logic [$clog2(DEPTH):0] ras_count;

  modport master (
    output en, load, call, ret, load_val,
    input  pc, ras_empty, ras_full, ras_err, ras_count
  );

  modport slave (
    input  en, load, call, ret, load_val,
    output pc, ras_empty, ras_full, ras_err, ras_count
  );
`else
  modport master (
    output en, load, call, ret, load_val,
    input  pc, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  en, load, call, ret, load_val,
    output pc, ras_empty, ras_full, ras_err
  );
`endif

endinterface

// File: rtl/pc_ras16.sv
// Program counter with a circular return-address stack (call/ret/jump/stall).
// Optional macro PC_RAS_COUNT_EN exports the stack entry count as bus.ras_count.
module pc_ras16 #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input logic       clk,
  input logic       reset,
  pc_ras16_if.slave bus
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CONFLICT,
    ACT_POP,
    ACT_UFLOW,
    ACT_PUSH,
    ACT_OFLOW,
    ACT_JUMP,
    ACT_STEP
  } act_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  act_e             act;
  logic             push_we;
  logic             empty;
  logic             full;
  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    top_idx;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign pc_inc  = pc_q + 1'b1;
  assign top_idx = wp_q - 1'b1;

  // wp_q is the next write slot; once full it also points at the oldest
  // entry, so an overflowing push naturally overwrites that entry.
  always_comb begin
    act = ACT_HOLD;
    if (bus.en) begin
      if (bus.call && bus.ret) begin
        act = ACT_CONFLICT;
      end else if (bus.ret) begin
        act = empty ? ACT_UFLOW : ACT_POP;
      end else if (bus.call) begin
        act = full ? ACT_OFLOW : ACT_PUSH;
      end else if (bus.load) begin
        act = ACT_JUMP;
      end else begin
        act = ACT_STEP;
      end
    end
  end

  always_comb begin
    pc_d    = pc_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push_we = 1'b0;
    unique case (act)
      ACT_HOLD: begin
      end
      ACT_CONFLICT: begin
        err_d = 1'b1;
      end
      ACT_POP: begin
        pc_d  = stack_q[top_idx];
        wp_d  = top_idx;
        cnt_d = cnt_q - 1'b1;
      end
      ACT_UFLOW: begin
        pc_d  = pc_inc;
        err_d = 1'b1;
      end
      ACT_PUSH: begin
        push_we = 1'b1;
        wp_d    = wp_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        pc_d    = bus.load_val;
      end
      ACT_OFLOW: begin
        push_we = 1'b1;
        wp_d    = wp_q + 1'b1;
        pc_d    = bus.load_val;
        err_d   = 1'b1;
      end
      ACT_JUMP: begin
        pc_d = bus.load_val;
      end
      ACT_STEP: begin
        pc_d = pc_inc;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      wp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack storage is not reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push_we && !reset) begin
      stack_q[wp_q] <= pc_inc;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_err   = err_q;

`ifdef PC_RAS_COUNT_EN
  assign bus.ras_count = cnt_q;
`endif

endmodule
